divider_iterative: RTL and testbench
====================================

Name: divider_iterative

Overview:
Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU instructions. It is the inverse-operation companion of the execute-stage iterative multiplier and sits beside it in EX. It uses the same start/done/busy handshake, so the hazard unit stalls the pipeline on div_use exactly as it does on mul_use. The normal path produces one quotient bit per cycle; divide-by-zero and signed overflow take a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width; the counter is $clog2(XLEN)+1 bits.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start_div  input  1  one-cycle start request; sampled only in IDLE
div_opcode  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
operand1  input  XLEN  dividend (rs1)
operand2  input  XLEN  divisor (rs2)
result_divide  output  XLEN  quotient or remainder; held until the next completion
done  output  1  one-cycle pulse; result_divide valid in the same cycle
div_use  output  1  busy, high from the start-accept edge until the done edge

Behaviour:
- Reset values: result_divide=0, done=0, div_use=0, state=IDLE, all internal registers 0. An asserted rst aborts any operation in progress; no done is produced for it.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On start_div=1 (edge E0), latch opcode, operands and the signedness flags. Signed ops are DIV/REM.
  - Load |dividend| into the quotient register (unsigned ops: raw value). Clear the 33-bit remainder register and the counter. Set div_use=1.
  - If the divisor is 0, or the op is DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF, set the special flag and go to FINISH.
  - Otherwise go to CALC.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1 and compute diff = rem - {1'b0,|divisor|}.
  - If diff >= 0: rem = diff, quo[0] = 1.
  - counter++. After the 32nd iteration (counter reaches XLEN), go to FINISH.
- FINISH, one edge:
  - Normal sign fix: quotient is negated when the op is signed and the operand signs differ. Remainder takes the sign of the dividend; a zero remainder stays 0.
  - Write result_divide: quotient for DIV/DIVU, remainder for REM/REMU.
  - Pulse done=1, set div_use=0, return to IDLE.
- Special results (RISC-V spec):
  - Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = dividend.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Latency, start edge to done:
  - Normal: 33 cycles (done high after edge E33).
  - Special: 1 cycle (done high after E1).
- Handshake:
  - start_div while div_use=1 is ignored; operands are not re-sampled.
  - start_div in the done cycle is accepted, since state is IDLE. That gives back-to-back operation with div_use low for that single cycle only.
  - done is never asserted in two consecutive cycles.
- Width rule: |0x80000000| is handled as an unsigned 0x80000000; no 33-bit operands are needed outside the remainder register.

Decomposition:
- Package rv32m_pkg holds:
  - div opcode localparams DIV/DIVU/REM/REMU;
  - typedef enum logic [1:0] div_state_t {IDLE, CALC, FINISH};
  - constants DIV_BY_ZERO_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module is natural: div_step, a purely combinational single restoring iteration. It takes {rem,quo} and the divisor and returns the next {rem,quo}. It is instantiated once inside the CALC datapath.

Test Plan:
- DIV 20 / -3 -> 0xFFFFFFFA after 33 cycles; REM 20 / -3 -> 0x00000002; REM -20 / 3 -> 0xFFFFFFFE; div_use high for 33 cycles, done pulses once.
- DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF; REMU 0xFFFFFFFF / 0x10 -> 0x0000000F; DIVU 7 / 9 -> 0, REMU 7 / 9 -> 7.
- DIV 5 / 0 -> 0xFFFFFFFF, REM 5 / 0 -> 0x00000005, REMU 0xDEADBEEF / 0 -> 0xDEADBEEF; each completes with done one cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM same operands -> 0, both in 1 cycle. DIVU with the same operands -> 0 via the normal 33-cycle path.
- Assert start_div with new operands at cycle 10 of a busy operation -> ignored, first result unchanged. A start issued in the done cycle is accepted and completes 33 cycles later.
- Assert rst at cycle 15 of DIV 100/7 -> all outputs 0 immediately and no done pulse. A new DIV 100/7 after reset -> 14 (0x0000000E).

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions for the execute-stage multiply/divide units.
// Holds divider opcodes, FSM state type and RISC-V special-case result constants.
package rv32m_pkg;

  localparam logic [1:0] DIV  = 2'b00;
  localparam logic [1:0] DIVU = 2'b01;
  localparam logic [1:0] REM  = 2'b10;
  localparam logic [1:0] REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } div_state_t;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN       = 32'h80000000;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Shifts {rem,quo} left by one and subtracts the divisor when it fits.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] divisor_ext;
  logic [XLEN:0] diff;
  logic          fits;

  always_comb begin
    rem_shift   = {rem[XLEN-1:0], quo[XLEN-1]};
    divisor_ext = {1'b0, divisor};
    diff        = rem_shift - divisor_ext;
    fits        = (rem_shift >= divisor_ext);
    rem_next    = fits ? diff : rem_shift;
    quo_next    = {quo[XLEN-2:0], fits};
  end

endmodule

// File: rtl/divider_iterative.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with start/done/busy handshake.
// Normal ops take 33 cycles; divide-by-zero and signed overflow finish in one.
module divider_iterative
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_div,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result_divide,
  output logic            done,
  output logic            div_use
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  div_state_t      state_q, state_d;
  logic [1:0]      opcode_q, opcode_d;
  logic            signed_q, signed_d;
  logic            div_neg_q, div_neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;

  div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  logic            in_signed;
  logic            in_neg1;
  logic            in_neg2;
  logic [XLEN-1:0] in_abs1;
  logic [XLEN-1:0] in_abs2;
  logic            in_zero;
  logic            in_ovf;
  logic            dvd_neg;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    // |INT_MIN| wraps to itself, which is the correct unsigned magnitude.
    in_signed = ~div_opcode[0];
    in_neg1   = in_signed & operand1[XLEN-1];
    in_neg2   = in_signed & operand2[XLEN-1];
    in_abs1   = in_neg1 ? -operand1 : operand1;
    in_abs2   = in_neg2 ? -operand2 : operand2;
    in_zero   = (operand2 == '0);
    in_ovf    = in_signed && (operand1 == XLEN'(INT_MIN)) && (operand2 == '1);

    dvd_neg   = signed_q & dividend_q[XLEN-1];
    if (special_q) begin
      quo_fix = (divisor_q == '0) ? XLEN'(DIV_BY_ZERO_Q) : XLEN'(INT_MIN);
      rem_fix = (divisor_q == '0) ? dividend_q : '0;
    end else begin
      quo_fix = (dvd_neg ^ div_neg_q) ? -quo_q : quo_q;
      rem_fix = dvd_neg ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    signed_d   = signed_q;
    div_neg_d  = div_neg_q;
    special_d  = special_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start_div) begin
          opcode_d   = div_opcode;
          signed_d   = in_signed;
          div_neg_d  = in_neg2;
          special_d  = in_zero | in_ovf;
          dividend_d = operand1;
          divisor_d  = in_abs2;
          quo_d      = in_abs1;
          rem_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = (in_zero | in_ovf) ? FINISH : CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        result_d = opcode_q[1] ? rem_fix : quo_fix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      opcode_q   <= '0;
      signed_q   <= 1'b0;
      div_neg_q  <= 1'b0;
      special_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      signed_q   <= signed_d;
      div_neg_q  <= div_neg_d;
      special_q  <= special_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign result_divide = result_q;
  assign done          = done_q;
  assign div_use       = busy_q;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: directed corner cases, handshake,
// reset abort and randomized ops against an arithmetic reference model.
module tb_divider_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_div = 1'b0;
  logic [1:0]  div_opcode = 2'b00;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [31:0] result_divide;
  logic        done;
  logic        div_use;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0 = 0;
  bit saw_done = 1'b0;

  divider_iterative #(
    .XLEN (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_div     (start_div),
    .div_opcode    (div_opcode),
    .operand1      (operand1),
    .operand2      (operand2),
    .result_divide (result_divide),
    .done          (done),
    .div_use       (div_use)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) saw_done = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_special(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
    if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : 32'h80000000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    div_opcode = op;
    operand1   = a;
    operand2   = b;
    start_div  = 1'b1;
    @(negedge clk);
    start_div  = 1'b0;
    e0 = cyc;
    check("accept/div_use", {31'd0, div_use}, 32'd1);
    check("accept/done_low", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
    bit busy_ok = 1'b1;
    while (!done && (cyc - e0) < 80) begin
      if (!div_use) busy_ok = 1'b0;
      @(negedge clk);
    end
    check({tag, "/done"}, {31'd0, done}, 32'd1);
    check({tag, "/lat"}, 32'(cyc - e0), 32'(exp_lat));
    check({tag, "/busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "/use_low"}, {31'd0, div_use}, 32'd0);
    check({tag, "/res"}, result_divide, exp_res);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{2'b00, 32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, "div20_m3"});
    vecs.push_back('{2'b10, 32'd20,         32'hFFFFFFFD, 32'h00000002, "rem20_m3"});
    vecs.push_back('{2'b10, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, "rem_m20_3"});
    vecs.push_back('{2'b01, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, "divu_max_1"});
    vecs.push_back('{2'b11, 32'hFFFFFFFF,   32'h10,       32'h0000000F, "remu_max_16"});
    vecs.push_back('{2'b01, 32'd7,          32'd9,        32'h00000000, "divu7_9"});
    vecs.push_back('{2'b11, 32'd7,          32'd9,        32'h00000007, "remu7_9"});
    vecs.push_back('{2'b00, 32'd5,          32'd0,        32'hFFFFFFFF, "div5_0"});
    vecs.push_back('{2'b10, 32'd5,          32'd0,        32'h00000005, "rem5_0"});
    vecs.push_back('{2'b11, 32'hDEADBEEF,   32'd0,        32'hDEADBEEF, "remu_dead_0"});
    vecs.push_back('{2'b01, 32'd5,          32'd0,        32'hFFFFFFFF, "divu5_0"});
    vecs.push_back('{2'b00, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf"});
    vecs.push_back('{2'b10, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
    vecs.push_back('{2'b01, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, "divu_ovf_ops"});
    vecs.push_back('{2'b00, 32'h80000000,   32'd2,        32'hC0000000, "div_min_2"});

    repeat (2) @(negedge clk);
    check("reset/res", result_divide, 32'd0);
    check("reset/done", {31'd0, done}, 32'd0);
    check("reset/use", {31'd0, div_use}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors issued back-to-back, each in the previous done cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].tag, vecs[i].exp,
                ref_special(vecs[i].op, vecs[i].a, vecs[i].b) ? 1 : 33);
    end

    // A start while busy must not disturb the running op.
    @(negedge clk);
    issue(2'b00, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    div_opcode = 2'b11;
    operand1   = 32'h12345678;
    operand2   = 32'd3;
    start_div  = 1'b1;
    @(negedge clk);
    start_div  = 1'b0;
    wait_done("ignore_busy", 32'd14, 33);
    issue(2'b01, 32'd1000, 32'd10);
    wait_done("done_cycle_start", 32'd100, 33);

    // Reset mid-operation aborts without a done pulse.
    issue(2'b00, 32'd100, 32'd7);
    repeat (15) @(negedge clk);
    saw_done = 1'b0;
    rst = 1'b1;
    #1;
    check("abort/res", result_divide, 32'd0);
    check("abort/done", {31'd0, done}, 32'd0);
    check("abort/use", {31'd0, div_use}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort/no_done", {31'd0, saw_done}, 32'd0);
    issue(2'b00, 32'd100, 32'd7);
    wait_done("after_abort", 32'h0000000E, 33);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          mode;
      op   = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        0:       b = 32'd0;
        1:       begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2:       begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3:       b = {{24{b[31]}}, b[7:0]};
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b);
      wait_done($sformatf("rnd%0d_op%0d_%h_%h", n, op, a, b), ref_result(op, a, b),
                ref_special(op, a, b) ? 1 : 33);
    end

    @(negedge clk);
    check("final/done_low", {31'd0, done}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
